// File: rtl/judge_ctrl.sv
// Rhythm-game judge: arms on a one-hot target and scores a key-press edge as a hit, or a wrong lane/timeout as a miss.
// All outputs are registered, so strobes and counters appear one clock after the deciding sample; there is no input backpressure.
module judge_ctrl #(
  parameter int MAX_WRONG = 5,
  parameter int TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       target_valid,
  input  logic [2:0] lane_target,
  input  logic [2:0] key,
  output logic [2:0] wrong_cnt,
  output logic [7:0] hit_cnt,
  output logic       wrong_pulse,
  output logic       round_done,
  output logic       busy,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_TGT = 2'd1,
    ARMED    = 2'd2,
    OVER     = 2'd3
  } state_t;

  localparam logic [2:0]  LP_MAX_WRONG = 3'(MAX_WRONG);
  localparam logic [15:0] LP_TIMEOUT   = 16'(TIMEOUT);

  state_t      r_state;
  logic [15:0] r_timer;
  logic [2:0]  r_target;
  logic [2:0]  r_key_q;
  logic [2:0]  r_wrong_cnt;
  logic [7:0]  r_hit_cnt;
  logic        r_wrong_pulse;
  logic        r_round_done;

  logic [2:0]  w_edge;
  logic        w_onehot;
  logic [2:0]  w_wrong_inc;
  logic [7:0]  w_hit_inc;

  assign w_edge      = key & ~r_key_q;
  assign w_onehot    = (lane_target == 3'b001) || (lane_target == 3'b010) || (lane_target == 3'b100);
  assign w_wrong_inc = (r_wrong_cnt == LP_MAX_WRONG) ? r_wrong_cnt : r_wrong_cnt + 3'd1;
  assign w_hit_inc   = (r_hit_cnt == 8'hFF) ? r_hit_cnt : r_hit_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_timer       <= 16'd0;
      r_target      <= 3'd0;
      r_key_q       <= 3'd0;
      r_wrong_cnt   <= 3'd0;
      r_hit_cnt     <= 8'd0;
      r_wrong_pulse <= 1'b0;
      r_round_done  <= 1'b0;
    end else begin
      r_key_q       <= key;
      r_wrong_pulse <= 1'b0;
      r_round_done  <= 1'b0;
      case (r_state)
        IDLE, OVER: begin
          if (start) begin
            r_state     <= WAIT_TGT;
            r_wrong_cnt <= 3'd0;
            r_hit_cnt   <= 8'd0;
          end
        end
        WAIT_TGT: begin
          if (target_valid && w_onehot) begin
            r_target <= lane_target;
            r_timer  <= LP_TIMEOUT;
            r_state  <= ARMED;
          end
        end
        ARMED: begin
          // A press edge outranks an expiring timer in the same cycle.
          if (w_edge == r_target) begin
            r_hit_cnt    <= w_hit_inc;
            r_round_done <= 1'b1;
            r_state      <= WAIT_TGT;
          end else if ((w_edge != 3'd0) || (r_timer == 16'd1)) begin
            r_wrong_cnt   <= w_wrong_inc;
            r_wrong_pulse <= 1'b1;
            r_round_done  <= 1'b1;
            r_state       <= (w_wrong_inc == LP_MAX_WRONG) ? OVER : WAIT_TGT;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wrong_cnt   = r_wrong_cnt;
  assign hit_cnt     = r_hit_cnt;
  assign wrong_pulse = r_wrong_pulse;
  assign round_done  = r_round_done;
  assign busy        = (r_state == WAIT_TGT) || (r_state == ARMED);
  assign game_over   = (r_state == OVER);

endmodule

// File: tb/tb_judge_ctrl.sv
// Scoreboard bench for judge_ctrl: stimulus pushes expected round results, a negedge monitor pops them on each strobe.
module tb_judge_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       target_valid;
  logic [2:0] lane_target;
  logic [2:0] key;
  logic [2:0] wrong_cnt;
  logic [7:0] hit_cnt;
  logic       wrong_pulse;
  logic       round_done;
  logic       busy;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       wp;
    logic [7:0] hit;
    logic [2:0] wrong;
  } exp_t;

  exp_t exp_q[$];
  int   m_hit   = 0;
  int   m_wrong = 0;

  judge_ctrl #(.MAX_WRONG(5), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .target_valid (target_valid),
    .lane_target  (lane_target),
    .key          (key),
    .wrong_cnt    (wrong_cnt),
    .hit_cnt      (hit_cnt),
    .wrong_pulse  (wrong_pulse),
    .round_done   (round_done),
    .busy         (busy),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  // Monitor: every strobe must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (round_done || wrong_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: got rd=%0b wp=%0b hit=%0d wrong=%0d, expected no strobe",
                   round_done, wrong_pulse, hit_cnt, wrong_cnt);
        end else begin
          e = exp_q.pop_front();
          if (!round_done || wrong_pulse !== e.wp || hit_cnt !== e.hit || wrong_cnt !== e.wrong) begin
            failures++;
            $display("FAIL round_result: got rd=%0b wp=%0b hit=%0d wrong=%0d, expected rd=1 wp=%0b hit=%0d wrong=%0d",
                     round_done, wrong_pulse, hit_cnt, wrong_cnt, e.wp, e.hit, e.wrong);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_hit();
    if (m_hit != 255) m_hit++;
    exp_q.push_back('{wp: 1'b0, hit: 8'(m_hit), wrong: 3'(m_wrong)});
  endtask

  task automatic exp_wrong();
    if (m_wrong != 5) m_wrong++;
    exp_q.push_back('{wp: 1'b1, hit: 8'(m_hit), wrong: 3'(m_wrong)});
  endtask

  task automatic arm(input logic [2:0] lane);
    target_valid = 1'b1;
    lane_target  = lane;
    step();
    target_valid = 1'b0;
    lane_target  = 3'b000;
  endtask

  task automatic press(input logic [2:0] k);
    key = k;
    step();
    key = 3'b000;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_hit   = 0;
    m_wrong = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target_valid = 1'b0; lane_target = 3'b000; key = 3'b000;
    step(); step();
    rst = 1'b0;
    chk("reset_hit", hit_cnt, 0);
    chk("reset_wrong", wrong_cnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_over", game_over, 0);
    chk("reset_strobes", {wrong_pulse, round_done}, 0);

    do_start();
    chk("start_busy", busy, 1);

    // Basic hit, then wrong lane, then a following target is still accepted.
    arm(3'b010); exp_hit(); press(3'b010);
    chk("after_hit_busy", busy, 1);
    arm(3'b001); exp_wrong(); press(3'b100);
    arm(3'b100); exp_hit(); press(3'b100);

    // Non-one-hot targets are ignored; edges in WAIT_TGT are ignored.
    arm(3'b011);
    arm(3'b000);
    press(3'b001);
    chk("non_onehot_busy", busy, 1);

    // Key held across the round boundary gives no second edge.
    arm(3'b010);
    exp_hit();
    key = 3'b010; step();
    arm(3'b010);
    step(); step();
    key = 3'b000; step();
    exp_hit();
    key = 3'b010; step();
    key = 3'b000; step();

    // Timeout on the 4th ARMED cycle, then a hit on exactly that cycle.
    arm(3'b100);
    exp_wrong();
    repeat (4) step();
    step();
    arm(3'b100);
    repeat (3) step();
    exp_hit(); press(3'b100);

    // Drive to game over, including a multi-key wrong.
    arm(3'b001); exp_wrong(); press(3'b011);
    arm(3'b010); exp_wrong(); press(3'b001);
    arm(3'b100); exp_wrong(); press(3'b010);
    chk("over_flag", game_over, 1);
    chk("over_busy", busy, 0);
    chk("over_wrong", wrong_cnt, 5);
    arm(3'b001); press(3'b001);
    chk("over_hold_hit", hit_cnt, 5);
    chk("over_hold_wrong", wrong_cnt, 5);
    chk("over_hold_flag", game_over, 1);

    do_start();
    chk("restart_hit", hit_cnt, 0);
    chk("restart_wrong", wrong_cnt, 0);
    chk("restart_busy", busy, 1);

    // Reset mid-round discards the round even with a matching press.
    arm(3'b010); exp_hit(); press(3'b010);
    arm(3'b001);
    rst = 1'b1; key = 3'b001;
    step();
    rst = 1'b0; key = 3'b000;
    m_hit = 0; m_wrong = 0;
    chk("midrst_hit", hit_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_over", game_over, 0);
    chk("midrst_strobes", {wrong_pulse, round_done}, 0);
    step();

    // Hit counter saturation.
    do_start();
    for (int i = 0; i < 256; i++) begin
      arm(3'b001 << (i % 3));
      exp_hit();
      press(3'b001 << (i % 3));
    end
    chk("hit_saturate", hit_cnt, 255);

    step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
